// File: rtl/assoc_wb_cache_if.sv
// Bus interfaces for assoc_wb_cache: a CPU request/response port and a word-wide
// memory beat port, each with master/slave views.

interface assoc_wb_cache_cpu_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_write_data;
    logic              cpu_ready;
    logic              cpu_done;
    logic              cpu_hit;
    logic [DATA_W-1:0] cpu_read_data;

    modport master (
        output cpu_req, cpu_write, cpu_address, cpu_write_data,
        input  cpu_ready, cpu_done, cpu_hit, cpu_read_data
    );
    modport slave (
        input  cpu_req, cpu_write, cpu_address, cpu_write_data,
        output cpu_ready, cpu_done, cpu_hit, cpu_read_data
    );
endinterface

interface assoc_wb_cache_mem_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_ready;

    modport master (
        output mem_req, mem_write, mem_address, mem_write_data,
        input  mem_read_data, mem_ready
    );
    modport slave (
        input  mem_req, mem_write, mem_address, mem_write_data,
        output mem_read_data, mem_ready
    );
endinterface

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back / write-allocate cache with LRU replacement.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.

module assoc_wb_cache #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 2,
    parameter int WAYS            = 2
) (
    input  logic clock,
    input  logic reset,
    assoc_wb_cache_cpu_if.slave  cpu,
    assoc_wb_cache_mem_if.master mem
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int WRD_W  = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_B  = $clog2(NUM_SETS);
    localparam int IDX_W  = (IDX_B > 0) ? IDX_B : 1;
    localparam int TAG_W  = ADDR_W - OFF_W - WRD_W - IDX_B;
    localparam int LINE_W = IDX_B + WRD_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
    } state_t;

    state_t state_reg, state_next;

    logic              req_write_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [DATA_W-1:0] req_data_reg;
    logic [WAY_W-1:0]  victim_reg;
    logic [WRD_W-1:0]  beat_reg;
    logic [DATA_W-1:0] read_data_reg;

    logic [WAYS-1:0]   valid_reg [NUM_SETS];
    logic [WAYS-1:0]   dirty_reg [NUM_SETS];
    logic [WAY_W-1:0]  lru_reg   [NUM_SETS];

    logic [TAG_W-1:0]  tag_mem  [WAYS][NUM_SETS];
    logic [DATA_W-1:0] data_mem [WAYS][NUM_SETS*WORDS_PER_BLOCK];

    logic [TAG_W-1:0]  req_tag;
    logic [LINE_W-1:0] req_flat;
    logic [LINE_W-1:0] beat_flat;
    logic [IDX_W-1:0]  req_set;
    logic [WAYS-1:0]   way_hit;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  miss_victim;
    logic [WAY_W-1:0]  access_way;
    logic              access_en;
    logic [DATA_W-1:0] access_result;
    logic              beat_done;
    logic              last_beat;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr_reg[OFF_W-1:0];

    assign req_tag   = req_addr_reg[ADDR_W-1 -: TAG_W];
    assign req_flat  = req_addr_reg[OFF_W +: LINE_W];
    assign req_set   = IDX_W'(req_flat >> WRD_W);
    // Same set as the request, word position replaced by the beat counter.
    assign beat_flat = (req_flat & ~LINE_W'(WORDS_PER_BLOCK - 1)) | LINE_W'(beat_reg);

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way_hit
            assign way_hit[gi] = valid_reg[req_set][gi] && (tag_mem[gi][req_set] == req_tag);
        end
    endgenerate

    assign hit = |way_hit;

    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) hit_way = WAY_W'(w);
        end
    end

    // Lowest-numbered invalid way wins over the LRU way.
    always_comb begin
        miss_victim = (WAYS > 1) ? lru_reg[req_set] : '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[req_set][w]) miss_victim = WAY_W'(w);
        end
    end

    assign access_en     = ((state_reg == S_LOOKUP) && hit) || (state_reg == S_RESPOND);
    assign access_way    = (state_reg == S_LOOKUP) ? hit_way : victim_reg;
    assign access_result = req_write_reg ? req_data_reg : data_mem[access_way][req_flat];
    assign beat_done     = mem.mem_req && mem.mem_ready;
    assign last_beat     = (beat_reg == WRD_W'(WORDS_PER_BLOCK - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next         = state_reg;
        cpu.cpu_ready      = 1'b0;
        cpu.cpu_done       = access_en;
        cpu.cpu_hit        = 1'b0;
        cpu.cpu_read_data  = access_en ? access_result : read_data_reg;
        mem.mem_req        = 1'b0;
        mem.mem_write      = 1'b0;
        mem.mem_address    = '0;
        mem.mem_write_data = '0;
        case (state_reg)
            S_IDLE: begin
                cpu.cpu_ready = 1'b1;
                if (cpu.cpu_req) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                cpu.cpu_hit = hit;
                if (hit)                              state_next = S_IDLE;
                else if (dirty_reg[req_set][miss_victim]) state_next = S_WRITEBACK;
                else                                  state_next = S_REFILL;
            end
            S_WRITEBACK: begin
                mem.mem_req        = 1'b1;
                mem.mem_write      = 1'b1;
                mem.mem_address    = (ADDR_W'(tag_mem[victim_reg][req_set]) << (ADDR_W - TAG_W))
                                   | (ADDR_W'(beat_flat) << OFF_W);
                mem.mem_write_data = data_mem[victim_reg][beat_flat];
                if (beat_done && last_beat) state_next = S_REFILL;
            end
            S_REFILL: begin
                mem.mem_req     = 1'b1;
                mem.mem_address = (ADDR_W'(req_tag) << (ADDR_W - TAG_W))
                                | (ADDR_W'(beat_flat) << OFF_W);
                if (beat_done && last_beat) state_next = S_RESPOND;
            end
            S_RESPOND: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_write_reg <= 1'b0;
            req_addr_reg  <= '0;
            req_data_reg  <= '0;
            victim_reg    <= '0;
            beat_reg      <= '0;
            read_data_reg <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                lru_reg[s]   <= '0;
            end
        end else begin
            if ((state_reg == S_IDLE) && cpu.cpu_req) begin
                req_write_reg <= cpu.cpu_write;
                req_addr_reg  <= cpu.cpu_address;
                req_data_reg  <= cpu.cpu_write_data;
            end
            // The victim is invalidated up front so an abandoned refill never looks valid.
            if ((state_reg == S_LOOKUP) && !hit) begin
                victim_reg                        <= miss_victim;
                beat_reg                          <= '0;
                valid_reg[req_set][miss_victim]   <= 1'b0;
            end
            if (beat_done) beat_reg <= beat_reg + WRD_W'(1);
            if ((state_reg == S_REFILL) && beat_done && last_beat) begin
                valid_reg[req_set][victim_reg] <= 1'b1;
                dirty_reg[req_set][victim_reg] <= 1'b0;
            end
            if (access_en) begin
                read_data_reg <= access_result;
                if (WAYS > 1) lru_reg[req_set] <= WAY_W'(access_way == '0);
                if (req_write_reg) dirty_reg[req_set][access_way] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if ((state_reg == S_REFILL) && beat_done) begin
            data_mem[victim_reg][beat_flat] <= mem.mem_read_data;
            if (last_beat) tag_mem[victim_reg][req_set] <= req_tag;
        end else if (access_en && req_write_reg) begin
            data_mem[access_way][req_flat] <= req_data_reg;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (access_en) begin
            if (state_reg == S_LOOKUP) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
- Clocked, parametrised N-way set-associative write-back, write-allocate cache between CPU request port and word-wide main memory.
- Successor to the lab's fixed direct-mapped cache.
- Adds configurable geometry, LRU replacement, an explicit valid/done handshake on both sides, and memory back-pressure.
- Fully synchronous; no delay statements.

Parameters:
- ADDR_W, 10, byte address width.
- DATA_W, 32, word width; byte offset = log2(DATA_W/8).
- WORDS_PER_BLOCK, 4, words per line; power of two, >=2.
- NUM_SETS, 2, sets; power of two, >=1.
- WAYS, 2, associativity; 1 or 2 (1 = direct-mapped, LRU unused).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  request valid; sampled only in IDLE
- cpu_write  in  1  1 = write, 0 = read
- cpu_address  in  ADDR_W  byte address; low 2 bits ignored
- cpu_write_data  in  DATA_W  store data
- cpu_ready  out  1  high only in IDLE
- cpu_done  out  1  one-cycle completion pulse
- cpu_hit  out  1  valid with cpu_done; 1 = request hit
- cpu_read_data  out  DATA_W  load result; held until next cpu_done
- mem_req  out  1  beat request
- mem_write  out  1  1 = writeback beat, 0 = refill beat
- mem_address  out  ADDR_W  word-aligned beat address
- mem_write_data  out  DATA_W  writeback data
- mem_read_data  in  DATA_W  refill data; valid when mem_ready
- mem_ready  in  1  beat completes on a clock edge where mem_req && mem_ready

Behaviour:
- Address split, MSB to LSB: tag | index (log2 NUM_SETS) | word (log2 WORDS_PER_BLOCK) | byte offset.
- Reset state:
  - all valid, dirty and LRU bits = 0;
  - state = IDLE;
  - all outputs 0, except cpu_ready = 1.
- Reset mid-operation: abandons the transaction immediately; mem_req drops asynchronously; no cpu_done; partially refilled line stays invalid.
- FSM IDLE:
  - cpu_req latches write, address and data;
  - next state LOOKUP.
- FSM LOOKUP:
  - hit = a valid way in the set with a matching tag.
  - Hit: perform the access; cpu_done = 1 and cpu_hit = 1 in this cycle; return to IDLE. Hit latency = 1 cycle after acceptance.
  - Miss, victim choice: lowest-numbered invalid way, else the LRU way.
  - Victim dirty: go to WRITEBACK; else go to REFILL.
- FSM WRITEBACK:
  - WORDS_PER_BLOCK beats, word 0 first;
  - mem_address = {victim tag, index, beat, 00}; mem_write = 1;
  - counter advances only on mem_ready; then REFILL.
- FSM REFILL:
  - WORDS_PER_BLOCK beats, mem_write = 0, mem_address = {tag, index, beat, 00};
  - each beat's data is captured on mem_ready;
  - after the last beat: tag written, valid = 1, dirty = 0; go to RESPOND.
- FSM RESPOND:
  - perform the access from the filled line;
  - cpu_done = 1, cpu_hit = 0; return to IDLE.
- Access rules:
  - Write: updates the word and sets dirty.
  - Read: returns the word.
  - Both update LRU so the accessed way becomes MRU.
- Back-pressure: mem_address, mem_write and mem_write_data stay stable while mem_req && !mem_ready.
- cpu_req outside IDLE is ignored. Holding cpu_req high in IDLE back-to-back is legal.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments on the cpu_done pulse that matches it: hit_count when cpu_hit = 1, miss_count when cpu_hit = 0.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: no ports, no counter logic.

Test Plan:
- Memory model word i = i (word i at byte address 4*i); defaults.
- 1. Reset, then read 0x1A8 -> miss. Four refill beats at 0x1A0, 0x1A4, 0x1A8, 0x1AC; no write beats; cpu_done with cpu_hit = 0 and cpu_read_data = 0x0000006A.
- 2. Write 0x1A8 with 0x3AB, then read 0x1A8 -> both hit; cpu_done 1 cycle after acceptance; no mem_req; read returns 0x000003AB.
- 3. Read 0x108 (same set 0) -> clean fill into way 1; no writeback. Then read 0x128 -> evicts LRU way 0 (dirty): four write beats 0x1A0..0x1AC carrying 0x68, 0x69, 0x3AB, 0x6B, then refill; returns 0x4A.
- 4. Read 0x1A8 -> miss, evicts clean 0x108 line with no writeback; returns 0x000003AB from memory.
- 5. Hold mem_ready low 3 cycles on refill beat 2 -> mem_address held at 0x1A8 for those cycles; cpu_done delayed by exactly 3 cycles.
- 6. Assert reset during refill beat 1 -> mem_req = 0 at once, cpu_ready = 1. Repeating the read misses again and refills 4 beats. With CACHE_STATS_EN, after scenarios 1-2: hit_count = 2, miss_count = 1.
